// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling 8N1 UART receiver with a small receive FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  // Half a bit lands the first sample mid start bit; full bits step mid-bit to mid-bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Synchroniser and edge-detect registers
  logic sync1;
  logic sync2;
  logic sync_prev;
  logic start_edge;

  // Receiver FSM state and datapath
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_n;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_n;
  logic             baud_done;
  logic             push_req;
  logic             ferr_n;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_n;
  logic [PTR_W-1:0] rd_n;
  logic [OCC_W-1:0] count;
  logic [OCC_W-1:0] count_n;
  logic             full;
  logic             push;
  logic             pop;
  logic             ovr_n;
  logic [7:0]       head_n;

  // Two-flop synchroniser plus a history flop; presets to idle-high so reset never fakes a start edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= uart_rx;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign start_edge = sync_prev & ~sync2;
  assign baud_done  = (baud_cnt == '0);

  // Receiver state, baud counter, bit index and shift register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
    end
  end

  // Next-state logic: every sample is taken when the baud counter reaches zero
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    shift_n  = shift_reg;
    push_req = 1'b0;
    ferr_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          baud_n  = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          if (sync2) begin
            // Line already back high mid start bit: treat as a glitch, silently
            state_n = IDLE;
          end else begin
            baud_n  = FULL_LOAD;
            bit_n   = '0;
            state_n = DATA;
          end
        end else begin
          baud_n = baud_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          shift_n[bit_idx] = sync2;
          baud_n           = FULL_LOAD;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          // Leave for IDLE right at mid stop bit so the next start edge is never missed
          state_n = IDLE;
          if (!sync2) begin
            ferr_n = 1'b1;
          end else begin
            push_req = 1'b1;
          end
        end else begin
          baud_n = baud_cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy  = (state != IDLE);
  assign rx_valid = (count != '0);
  assign full     = (count == DEPTH_C);
  assign pop      = rx_valid & rx_ready;
  // A full FIFO still takes the byte when the consumer frees a slot in the same cycle
  assign push     = push_req & (~full | pop);
  assign ovr_n    = push_req & full & ~pop;
  assign wr_n     = wr_ptr + PTR_W'(push);
  assign rd_n     = rd_ptr + PTR_W'(pop);

  // Occupancy after this cycle's push and pop
  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + OCC_W'(1);
      2'b01:   count_n = count - OCC_W'(1);
      default: count_n = count;
    endcase
  end

  // Head value after this cycle; a byte pushed into an otherwise empty FIFO bypasses storage
  always_comb begin
    head_n = rx_data;
    if (count_n != '0) begin
      if (push && (wr_ptr == rd_n)) begin
        head_n = shift_reg;
      end else begin
        head_n = mem[rd_n];
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  // FIFO pointers, occupancy, registered head and the one-cycle status pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_ptr    <= wr_n;
      rd_ptr    <= rd_n;
      count     <= count_n;
      rx_data   <= head_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Start detection 3 clk after the fall, then half a bit to mid start, then 9 bits to mid stop
  localparam int STOP_OFS  = 3 + CPB / 2 + 9 * CPB;
  localparam int START_OFS = 3 + CPB / 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    bit         ferr;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  bit         exp_fe = 0;
  bit         exp_ov = 0;
  int         busy_lo = 0;
  int         busy_hi = 0;
  bit         m_pop;
  bit         m_push;
  logic [7:0] m_pd;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         checking = 0;
  bit         rand_rdy = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vcyc = 0;
  int         first_v = -1;
  logic [7:0] last_v = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue plus scheduled mid-stop-bit outcomes, advanced once per edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      exp_fe = 0;
      exp_ov = 0;
      if (!reset_n) begin
        mq.delete();
        evq.delete();
        busy_hi = 0;
      end else begin
        m_pop  = (mq.size() > 0) && rx_ready;
        m_push = 0;
        m_pd   = 8'h00;
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].edge_no == cyc) begin
            if (evq[i].ferr) begin
              exp_fe = 1;
            end else if (mq.size() - int'(m_pop) < DEPTH) begin
              m_push = 1;
              m_pd   = evq[i].data;
            end else begin
              exp_ov = 1;
            end
            evq.delete(i);
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(m_pd);
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, mq.size() != 0});
        chk("fifo_count", {29'd0, fifo_count}, mq.size());
        if (mq.size() != 0) chk("rx_data", {24'd0, rx_data}, {24'd0, mq[0]});
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ov});
        chk("rx_busy", {31'd0, rx_busy}, {31'd0, (cyc >= busy_lo) && (cyc < busy_hi)});
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (rx_valid === 1'b1) begin
          vcyc++;
          last_v = rx_data;
          if (first_v < 0) first_v = cyc;
        end
      end
    end
  end

  // Random consumer back-pressure, only while enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation ran out of time");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    fe_cnt  = 0;
    ov_cnt  = 0;
    vcyc    = 0;
    first_v = -1;
  endtask

  // Drives one 8N1 frame starting now; abort_bit >= 0 pulses reset mid that data bit
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_bit, output int f);
    logic v;
    f = cyc;
    busy_lo = f + 3;
    busy_hi = f + STOP_OFS;
    evq.push_back('{f + STOP_OFS, !stop_ok, b});
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : (k == 9) ? stop_ok : b[k-1];
      uart_rx = v;
      if (abort_bit >= 0 && k == abort_bit + 1) begin
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        uart_rx = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic glitch();
    int f;
    f = cyc;
    busy_lo = f + 3;
    busy_hi = f + START_OFS;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
  endtask

  task automatic pop_check(input logic [7:0] exp);
    chk("pop_valid", {31'd0, rx_valid}, 32'd1);
    chk("pop_data", {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    int f;
    logic [7:0] b;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    checking = 1;
    chk("reset_rx_data", {24'd0, rx_data}, 32'h0);

    // Idle line
    clr_counts();
    idle(500);
    chk("idle_valid", {31'd0, rx_valid}, 32'd0);
    chk("idle_busy", {31'd0, rx_busy}, 32'd0);
    chk("idle_count", {29'd0, fifo_count}, 32'd0);
    chk("idle_pulses", fe_cnt + ov_cnt, 32'd0);

    // Single byte, consumer always ready
    clr_counts();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1, -1, f);
    idle(40);
    chk("a5_valid_cycles", vcyc, 32'd1);
    chk("a5_data", {24'd0, last_v}, 32'hA5);
    chk("a5_latency", first_v - f, 32'd155);
    chk("a5_pulses", fe_cnt + ov_cnt, 32'd0);

    // Five back-to-back bytes into a 4-deep FIFO with no consumer
    clr_counts();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, -1, f);
    idle(20);
    chk("ovr_count", {29'd0, fifo_count}, 32'd4);
    chk("ovr_pulses", ov_cnt, 32'd1);
    for (int i = 1; i <= 4; i++) pop_check(8'(i));
    chk("ovr_drained", {31'd0, rx_valid}, 32'd0);

    // Framing error, then a good frame
    clr_counts();
    send_frame(8'h3C, 0, -1, f);
    idle(CPB);
    chk("ferr_pulses", fe_cnt, 32'd1);
    chk("ferr_count", {29'd0, fifo_count}, 32'd0);
    clr_counts();
    rx_ready = 1'b1;
    send_frame(8'h7E, 1, -1, f);
    idle(40);
    chk("after_ferr_data", {24'd0, last_v}, 32'h7E);
    chk("after_ferr_valid", vcyc, 32'd1);

    // Short low glitch on an idle line
    clr_counts();
    glitch();
    idle(3 * CPB);
    chk("glitch_pulses", fe_cnt + ov_cnt, 32'd0);
    chk("glitch_valid", vcyc, 32'd0);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);

    // Reset mid frame, then a clean byte
    send_frame(8'hE7, 1, 4, f);
    idle(3 * CPB);
    clr_counts();
    send_frame(8'h55, 1, -1, f);
    idle(40);
    chk("post_reset_data", {24'd0, last_v}, 32'h55);
    chk("post_reset_valid", vcyc, 32'd1);
    chk("post_reset_pulses", fe_cnt + ov_cnt, 32'd0);

    // Random frames, random framing errors, random gaps and back-pressure
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, -1, f);
      idle(ok ? $urandom_range(0, 30) : CPB + $urandom_range(0, 30));
    end
    rand_rdy = 0;
    rx_ready = 1'b1;
    idle(20);
    chk("final_count", {29'd0, fifo_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
